// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-lite bus bundle between one master and the SRAM slave.
// The slave modport drives the response signals; the master drives everything else.
interface ahb_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic [1:0]            hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize,
    output hburst, hprot, hready, hwdata,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize,
    input  hburst, hprot, hready, hwdata,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite slave backed by a flop word memory with wait states,
// byte-lane writes and a two-cycle ERROR response for illegal transfers.
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic hclk,
  input logic hreset,
  ahb_lite_sram_slave_if.slave bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = $clog2(MEM_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_active;
  logic                  r_write;
  logic [1:0]            r_size;
  logic [IDXW-1:0]       r_idx;
  logic [LSB-1:0]        r_lane;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_inrange;
  logic                  w_size_ok;
  logic [2:0]            w_amask;
  logic                  w_aligned;
  logic                  w_legal;
  logic                  w_req;
  logic                  w_acc;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_rd;
  logic [NB-1:0]         w_be;
  logic                  w_unused;

  always_comb begin
    w_off     = bus.haddr - BASE_ADDR;
    w_inrange = (w_off >> (LSB + IDXW)) == '0;
    w_size_ok = bus.hsize <= 3'(LSB);
    w_amask   = 3'((4'd1 << bus.hsize[1:0]) - 4'd1);
    w_aligned = (bus.haddr[2:0] & w_amask) == 3'd0;
    w_legal   = w_inrange & w_size_ok & w_aligned;
    w_req     = bus.hsel & bus.htrans[1];
    w_acc     = bus.hready &
                ((r_state == S_IDLE) | (r_state == S_ERR2));
    w_done    = r_active & (r_state == S_IDLE);
    w_rd      = r_mem[r_idx];
  end

  // Lane b is written when it falls in the same size-aligned chunk as the address.
  always_comb begin
    w_be = '0;
    for (int b = 0; b < NB; b++)
      w_be[b] = (b >> r_size) == (int'(r_lane) >> r_size);
  end

  assign w_unused = ^{bus.hburst, bus.hprot,
                      bus.htrans[0], w_off[LSB-1:0]};

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_write  <= 1'b0;
      r_size   <= '0;
      r_idx    <= '0;
      r_lane   <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_done && !r_write)
        r_rdata <= w_rd;
      if (w_acc) begin
        r_active <= w_req & w_legal;
        r_write  <= bus.hwrite;
        r_size   <= bus.hsize[1:0];
        r_idx    <= w_off[LSB +: IDXW];
        r_lane   <= bus.haddr[LSB-1:0];
        if (w_req && !w_legal) begin
          r_state <= S_ERR1;
        end else if (w_req && WAIT_STATES > 0) begin
          r_state <= S_WAIT;
          r_cnt   <= 4'(WAIT_STATES);
        end else begin
          r_state <= S_IDLE;
        end
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1)
          r_state <= S_IDLE;
      end else if (r_state == S_ERR1) begin
        r_state <= S_ERR2;
      end
    end
  end

  // Memory is deliberately not reset; a reset clears r_active so no write lands.
  always_ff @(posedge hclk) begin
    if (w_done && r_write) begin
      for (int b = 0; b < NB; b++)
        if (w_be[b])
          r_mem[r_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
    end
  end

  assign bus.hreadyout = (r_state == S_IDLE) | (r_state == S_ERR2);
  assign bus.hresp     = {1'b0, (r_state == S_ERR1) | (r_state == S_ERR2)};
  assign bus.hrdata    = (r_active && !r_write) ? w_rd : r_rdata;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: four slaves with WAIT_STATES 0..3 share one master;
// sel picks which slave is addressed and which one drives hready.
module tb_ahb_lite_sram_slave;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] rd   [4];
  logic        rdy  [4];
  logic [1:0]  resp [4];
  logic        hready;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign hready = rdy[sel];

  for (genvar k = 0; k < 4; k++) begin : g
    ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.hsel   = hsel & (sel == k);
    assign bus.haddr  = haddr;
    assign bus.htrans = htrans;
    assign bus.hwrite = hwrite;
    assign bus.hsize  = hsize;
    assign bus.hburst = 3'b010;
    assign bus.hprot  = 4'b0011;
    assign bus.hready = hready;
    assign bus.hwdata = hwdata;
    assign rd[k]   = bus.hrdata;
    assign rdy[k]  = bus.hreadyout;
    assign resp[k] = bus.hresp;
    ahb_lite_sram_slave #(.WAIT_STATES(k)) dut (
      .hclk   (clk),
      .hreset (rst),
      .bus    (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic [31:0] a, input logic [1:0] t,
                    input logic w, input logic [2:0] s);
    hsel   = 1'b1;
    haddr  = a;
    htrans = t;
    hwrite = w;
    hsize  = s;
  endtask

  task automatic idle();
    hsel   = 1'b0;
    htrans = T_IDLE;
  endtask

  task automatic err_seq(input string tag);
    step();
    chk({tag, "_rdy1"}, 32'(rdy[sel]), 32'd0);
    chk({tag, "_rsp1"}, 32'(resp[sel]), 32'd1);
    idle();
    step();
    chk({tag, "_rdy2"}, 32'(rdy[sel]), 32'd1);
    chk({tag, "_rsp2"}, 32'(resp[sel]), 32'd1);
  endtask

  // WRAP4 with a BUSY after beat 2; WAIT_STATES=1 gives two cycles per beat.
  task automatic burst(input logic wr);
    logic [31:0] addrs [5];
    logic [1:0]  trs   [5];
    addrs = '{32'h38, 32'h3C, 32'h30, 32'h30, 32'h34};
    trs   = '{T_NS, T_SEQ, T_BUSY, T_SEQ, T_SEQ};
    for (int j = 0; j < 5; j++) begin
      ap(addrs[j], trs[j], wr, 3'd2);
      step();
      if (trs[j] == T_BUSY) begin
        chk("busy_rdy", 32'(rdy[sel]), 32'd1);
        chk("busy_rsp", 32'(resp[sel]), 32'd0);
      end else begin
        chk("beat_wait", 32'(rdy[sel]), 32'd0);
        if (wr) hwdata = 32'hB000_0000 | addrs[j];
        idle();
        step();
        chk("beat_done", 32'(rdy[sel]), 32'd1);
        chk("beat_rsp", 32'(resp[sel]), 32'd0);
        if (!wr)
          chk("beat_data", rd[sel], 32'hB000_0000 | addrs[j]);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    sel = 2'd0;
    hwdata = '0;
    haddr = '0;
    hwrite = 1'b0;
    hsize = 3'd2;
    idle();
    step();
    chk("rst_rdy", 32'(rdy[0]), 32'd1);
    chk("rst_rsp", 32'(resp[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'd0);
    step();
    rst = 1'b0;
    step();

    ap(32'h04, T_NS, 1'b1, 3'd2);
    step();
    chk("wr_rdy", 32'(rdy[0]), 32'd1);
    hwdata = 32'hDEADBEEF;
    ap(32'h04, T_NS, 1'b0, 3'd2);
    step();
    chk("rd_rdy", 32'(rdy[0]), 32'd1);
    chk("rd_rsp", 32'(resp[0]), 32'd0);
    chk("rd_word", rd[0], 32'hDEADBEEF);
    idle();
    step();
    chk("rd_hold", rd[0], 32'hDEADBEEF);

    ap(32'h08, T_NS, 1'b1, 3'd2);
    step();
    hwdata = 32'h11223344;
    ap(32'h0A, T_NS, 1'b1, 3'd0);
    step();
    hwdata = 32'h00AA0000;
    ap(32'h0C, T_NS, 1'b1, 3'd2);
    step();
    hwdata = 32'h55667788;
    ap(32'h0C, T_NS, 1'b1, 3'd1);
    step();
    hwdata = 32'h0000CCDD;
    ap(32'h08, T_NS, 1'b0, 3'd2);
    step();
    chk("byte_lane", rd[0], 32'h11AA3344);
    ap(32'h0C, T_NS, 1'b0, 3'd2);
    step();
    chk("half_lane", rd[0], 32'h5566CCDD);
    idle();
    step();

    sel = 2'd3;
    ap(32'h20, T_NS, 1'b1, 3'd2);
    step();
    hwdata = 32'hCAFEF00D;
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("ws3_wr_low", 32'(rdy[3]), 32'd0);
      step();
    end
    chk("ws3_wr_done", 32'(rdy[3]), 32'd1);
    ap(32'h20, T_NS, 1'b0, 3'd2);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("ws3_rd_low", 32'(rdy[3]), 32'd0);
      chk("ws3_rd_rsp", 32'(resp[3]), 32'd0);
      step();
    end
    chk("ws3_rd_done", 32'(rdy[3]), 32'd1);
    chk("ws3_rd_rsp2", 32'(resp[3]), 32'd0);
    chk("ws3_rd_data", rd[3], 32'hCAFEF00D);
    step();

    sel = 2'd0;
    ap(32'h400, T_NS, 1'b0, 3'd2);
    err_seq("err_range");
    step();
    chk("err_after", 32'(resp[0]), 32'd0);
    ap(32'h01, T_NS, 1'b0, 3'd1);
    err_seq("err_half");
    ap(32'h00, T_NS, 1'b0, 3'd3);
    err_seq("err_size");
    ap(32'h05, T_NS, 1'b1, 3'd2);
    hwdata = 32'hFFFFFFFF;
    err_seq("err_wr");
    ap(32'h04, T_NS, 1'b0, 3'd2);
    step();
    chk("err_wr_mem", rd[0], 32'hDEADBEEF);
    idle();
    step();

    sel = 2'd1;
    burst(1'b1);
    step();
    burst(1'b0);
    step();

    sel = 2'd2;
    ap(32'h10, T_NS, 1'b1, 3'd2);
    step();
    hwdata = 32'h12345678;
    idle();
    step();
    step();
    chk("ws2_wr_done", 32'(rdy[2]), 32'd1);
    ap(32'h10, T_NS, 1'b0, 3'd2);
    step();
    idle();
    step();
    step();
    chk("ws2_rd_data", rd[2], 32'h12345678);
    ap(32'h10, T_NS, 1'b1, 3'd2);
    step();
    hwdata = 32'h87654321;
    idle();
    chk("mid_wait", 32'(rdy[2]), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(rdy[2]), 32'd1);
    chk("mid_rst_rsp", 32'(resp[2]), 32'd0);
    chk("mid_rst_rdata", rd[2], 32'd0);
    step();
    rst = 1'b0;
    step();
    ap(32'h10, T_NS, 1'b0, 3'd2);
    step();
    idle();
    step();
    step();
    chk("rst_drop_rdy", 32'(rdy[2]), 32'd1);
    chk("rst_drop_wr", rd[2], 32'h12345678);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
